// File: rtl/exe_stage.sv
// Execute stage: one-instruction pipeline register, single-cycle ALU, iterative
// 32-step restoring divider, data-SRAM request issue and forwarding view to decode.
//
// div state | meaning
// IDLE      | no divide in progress
// BUSY      | one quotient bit per cycle, count 0..31
// DONE      | result valid, waiting for handoff to memory stage
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 151,
  parameter int ES_TO_MS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic                       es_fwd_we,
  output logic [4:0]                 es_fwd_dest,
  output logic [31:0]                es_fwd_data,
  output logic                       es_fwd_is_load
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic                       es_valid;
  logic                       es_ready_go;
  logic [DS_TO_ES_BUS_WD-1:0] es_bus;

  logic [11:0] alu_op;
  logic        div_en, div_signed, div_mod, res_from_mem, gr_we, mem_we;
  logic [4:0]  dest;
  logic [31:0] src1, src2, rkd_value, pc;

  assign {alu_op, div_en, div_signed, div_mod, res_from_mem, gr_we, mem_we,
          dest, src1, src2, rkd_value, pc} = es_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
      es_bus   <= '0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) es_bus <= ds_to_es_bus;
    end
  end

  // ALU
  logic [31:0] add_res, alu_result;
  logic [4:0]  shamt;
  assign add_res = src1 + src2;
  assign shamt   = src2[4:0];

  always_comb begin
    alu_result = '0;
    if      (alu_op[0])  alu_result = add_res;
    else if (alu_op[1])  alu_result = src1 - src2;
    else if (alu_op[2])  alu_result = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[3])  alu_result = {31'd0, src1 < src2};
    else if (alu_op[4])  alu_result = src1 & src2;
    else if (alu_op[5])  alu_result = ~(src1 | src2);
    else if (alu_op[6])  alu_result = src1 | src2;
    else if (alu_op[7])  alu_result = src1 ^ src2;
    else if (alu_op[8])  alu_result = src1 << shamt;
    else if (alu_op[9])  alu_result = src1 >> shamt;
    else if (alu_op[10]) alu_result = $unsigned($signed(src1) >>> shamt);
    else if (alu_op[11]) alu_result = src2;
  end

  // Divider
  div_state_t  div_state, div_state_nxt;
  logic [4:0]  div_count;
  logic [31:0] div_rem, div_quo, div_dvs;
  logic        div_q_neg, div_r_neg, div_dvs_zero;
  logic        div_start, handoff;
  logic [32:0] div_partial, div_diff;
  logic        div_ge;
  logic [31:0] div_rem_step;
  logic [31:0] div_q_final, div_r_final, div_result;

  assign div_start = es_valid && div_en && (div_state == DIV_IDLE);
  assign handoff   = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_state <= DIV_IDLE;
    else       div_state <= div_state_nxt;
  end

  always_comb begin
    div_state_nxt = div_state;
    case (div_state)
      DIV_IDLE: if (div_start) div_state_nxt = DIV_BUSY;
      DIV_BUSY: if (div_count == 5'd31) div_state_nxt = DIV_DONE;
      DIV_DONE: if (handoff) div_state_nxt = DIV_IDLE;
      default:  div_state_nxt = DIV_IDLE;
    endcase
  end

  // Dividend bits shift out of div_quo's MSB while quotient bits shift in at the LSB.
  assign div_partial  = {div_rem, div_quo[31]};
  assign div_diff     = div_partial - {1'b0, div_dvs};
  assign div_ge       = div_partial >= {1'b0, div_dvs};
  assign div_rem_step = div_ge ? div_diff[31:0] : div_partial[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_count    <= '0;
      div_rem      <= '0;
      div_quo      <= '0;
      div_dvs      <= '0;
      div_q_neg    <= 1'b0;
      div_r_neg    <= 1'b0;
      div_dvs_zero <= 1'b0;
    end else if (div_start) begin
      div_count    <= '0;
      div_rem      <= '0;
      div_quo      <= (div_signed && src1[31]) ? -src1 : src1;
      div_dvs      <= (div_signed && src2[31]) ? -src2 : src2;
      div_q_neg    <= div_signed && (src1[31] ^ src2[31]);
      div_r_neg    <= div_signed && src1[31];
      div_dvs_zero <= (src2 == 32'd0);
    end else if (div_state == DIV_BUSY) begin
      div_rem   <= div_rem_step;
      div_quo   <= {div_quo[30:0], div_ge};
      div_count <= div_count + 5'd1;
    end
  end

  // A zero divisor leaves the dividend in div_rem, so only the quotient needs overriding.
  assign div_q_final = div_dvs_zero ? 32'hFFFF_FFFF : (div_q_neg ? -div_quo : div_quo);
  assign div_r_final = div_r_neg ? -div_rem : div_rem;
  assign div_result  = div_mod ? div_r_final : div_q_final;

  // Handshake and outputs
  logic [31:0] es_result;
  assign es_result = div_en ? div_result : (res_from_mem ? add_res : alu_result);

  assign es_ready_go    = !div_en || (div_state == DIV_DONE);
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign es_to_ms_bus   = {res_from_mem, gr_we, dest, es_result, pc};

  assign data_sram_en    = es_valid && (res_from_mem || mem_we) && ms_allowin;
  assign data_sram_we    = {4{es_valid && mem_we && ms_allowin}};
  assign data_sram_addr  = add_res;
  assign data_sram_wdata = rkd_value;

  assign es_fwd_we      = es_valid && gr_we && (dest != 5'd0);
  assign es_fwd_dest    = dest;
  assign es_fwd_data    = es_result;
  assign es_fwd_is_load = es_valid && (res_from_mem || (div_en && (div_state != DIV_DONE)));

endmodule
